// File: rtl/add_serial_pkg.sv
// Shared FSM encoding and default sizing for the serial-adder sequencer.
package add_serial_pkg;
    localparam int ADD_WIDTH = 8;
    localparam int ADD_LAT   = 9;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_WAIT = 3'd2,
        ST_CAPT = 3'd3,
        ST_REL  = 3'd4
    } state_t;
endpackage

// File: rtl/sync_fifo2.sv
// Two-entry synchronous FIFO, head visible combinationally; zero-latency read.
// Push while full and pop while empty are ignored, so callers gate on full/empty.
module sync_fifo2 #(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_push,
    input  logic [DW-1:0] i_push_dat,
    input  logic          i_pop,
    output logic [DW-1:0] o_head_dat,
    output logic          o_full,
    output logic          o_empty
);
    logic [DW-1:0] r_mem [2];
    logic          r_wr_ptr;
    logic          r_rd_ptr;
    logic [1:0]    r_cnt;
    logic          w_push;
    logic          w_pop;

    assign w_push = i_push && !o_full;
    assign w_pop  = i_pop && !o_empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_cnt    <= 2'd0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= i_push_dat;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            r_cnt <= r_cnt + {1'b0, w_push} - {1'b0, w_pop};
        end
    end

    assign o_head_dat = r_mem[r_rd_ptr];
    assign o_full     = (r_cnt == 2'd2);
    assign o_empty    = (r_cnt == 2'd0);
endmodule

// File: rtl/add_serial_seq.sv
// Feeds buffered operand pairs to a multi-cycle serial adder and checks/queues its sums.
// One op per LAT+3 cycles; stalls in IDLE until an input pair and a free result slot exist.
module add_serial_seq
    import add_serial_pkg::*;
#(
    parameter int WIDTH = ADD_WIDTH,
    parameter int LAT   = ADD_LAT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             add_en,
    output logic [WIDTH-1:0] add_a,
    output logic [WIDTH-1:0] add_b,
    input  logic [WIDTH-1:0] add_out,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_sum,
    output logic             chk_err,
    output logic [15:0]      op_cnt
);
    localparam int CW = $clog2(LAT) + 1;

    state_t             r_state;
    logic [CW-1:0]      r_wait_cnt;
    logic [WIDTH-1:0]   r_held_a;
    logic [WIDTH-1:0]   r_held_b;
    logic               r_add_en;
    logic               r_chk_err;
    logic [15:0]        r_op_cnt;

    logic               w_in_full;
    logic               w_in_empty;
    logic               w_res_full;
    logic               w_res_empty;
    logic               w_start;
    logic               w_capt;
    logic [2*WIDTH-1:0] w_in_head;
    logic [WIDTH-1:0]   w_sum_exp;

    assign in_ready  = !w_in_full;
    assign res_valid = !w_res_empty;
    // Only one op is ever in flight, so a free result slot at start cannot be stolen before CAPT.
    assign w_start   = (r_state == ST_IDLE) && !w_in_empty && !w_res_full;
    assign w_capt    = (r_state == ST_CAPT);
    assign w_sum_exp = r_held_a + r_held_b;

    sync_fifo2 #(.DW(2*WIDTH)) u_in_fifo (
        .clk        (clk),
        .rst        (rst),
        .i_push     (in_valid && in_ready),
        .i_push_dat ({in_a, in_b}),
        .i_pop      (w_start),
        .o_head_dat (w_in_head),
        .o_full     (w_in_full),
        .o_empty    (w_in_empty)
    );

    sync_fifo2 #(.DW(WIDTH)) u_res_fifo (
        .clk        (clk),
        .rst        (rst),
        .i_push     (w_capt),
        .i_push_dat (add_out),
        .i_pop      (res_ready),
        .o_head_dat (res_sum),
        .o_full     (w_res_full),
        .o_empty    (w_res_empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_wait_cnt <= '0;
            r_held_a   <= '0;
            r_held_b   <= '0;
            r_add_en   <= 1'b0;
            r_chk_err  <= 1'b0;
            r_op_cnt   <= 16'd0;
        end else begin
            r_add_en <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_start) begin
                        r_held_a <= w_in_head[2*WIDTH-1:WIDTH];
                        r_held_b <= w_in_head[WIDTH-1:0];
                        r_add_en <= 1'b1;
                        r_state  <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    r_wait_cnt <= '0;
                    r_state    <= ST_WAIT;
                end
                ST_WAIT: begin
                    // Counter lands on LAT-1 on the same edge that enters CAPT.
                    r_wait_cnt <= r_wait_cnt + 1'b1;
                    if (r_wait_cnt == CW'(LAT - 2)) begin
                        r_state <= ST_CAPT;
                    end
                end
                ST_CAPT: begin
                    if (add_out != w_sum_exp) begin
                        r_chk_err <= 1'b1;
                    end
                    r_op_cnt <= r_op_cnt + 16'd1;
                    r_add_en <= 1'b1;
                    r_state  <= ST_REL;
                end
                ST_REL: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign add_en  = r_add_en;
    assign add_a   = r_held_a;
    assign add_b   = r_held_b;
    assign chk_err = r_chk_err;
    assign op_cnt  = r_op_cnt;
endmodule

// File: tb/tb_add_serial_seq.sv
// Directed bench for add_serial_seq with a behavioural serial adder of latency LAT.
module tb_add_serial_seq;
    localparam int LAT = 9;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  in_a = 8'h00;
    logic [7:0]  in_b = 8'h00;
    logic        add_en;
    logic [7:0]  add_a;
    logic [7:0]  add_b;
    logic [7:0]  add_out;
    logic        res_valid;
    logic        res_ready = 1'b0;
    logic [7:0]  res_sum;
    logic        chk_err;
    logic [15:0] op_cnt;

    int checks = 0;
    int errors = 0;
    int en_cnt = 0;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] sum;
        logic       err;
    } vec_t;
    vec_t vecs[6];

    add_serial_seq #(.WIDTH(8), .LAT(LAT)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .add_en    (add_en),
        .add_a     (add_a),
        .add_b     (add_b),
        .add_out   (add_out),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_sum   (res_sum),
        .chk_err   (chk_err),
        .op_cnt    (op_cnt)
    );

    always #5 clk = ~clk;

    // Adder model: add_en starts it, sum valid LAT edges after add_en rises, add_en again releases it.
    int         m_state = 0;
    int         m_cnt = 0;
    logic [7:0] m_sum = 8'h00;
    always @(posedge clk) begin
        if (rst) begin
            m_state <= 0;
            m_cnt   <= 0;
            add_out <= 8'h00;
        end else begin
            case (m_state)
                0: if (add_en) begin
                    m_state <= 1;
                    m_cnt   <= 1;
                    m_sum   <= (add_a == 8'h10 && add_b == 8'h20) ? 8'h00 : add_a + add_b;
                    add_out <= 8'hEE;
                end
                1: begin
                    m_cnt <= m_cnt + 1;
                    if (m_cnt == LAT - 1) begin
                        add_out <= m_sum;
                        m_state <= 2;
                    end
                end
                default: if (add_en) m_state <= 0;
            endcase
        end
    end

    always @(negedge clk) if (add_en) en_cnt <= en_cnt + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_reset_outputs();
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_res_valid", 32'(res_valid), 32'd0);
        check("rst_res_sum", 32'(res_sum), 32'd0);
        check("rst_add_en", 32'(add_en), 32'd0);
        check("rst_add_a", 32'(add_a), 32'd0);
        check("rst_add_b", 32'(add_b), 32'd0);
        check("rst_chk_err", 32'(chk_err), 32'd0);
        check("rst_op_cnt", 32'(op_cnt), 32'd0);
    endtask

    // Called at a negedge; returns at the negedge after the pair is accepted.
    task automatic push(input logic [7:0] a, input logic [7:0] b);
        int n = 0;
        in_valid = 1'b1;
        in_a = a;
        in_b = b;
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("push_timeout", 32'(n >= 100), 32'd0);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic pop_expect(input string name, input logic [7:0] exp);
        int n = 0;
        while (!res_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        check({name, "_valid"}, 32'(res_valid), 32'd1);
        check(name, 32'(res_sum), 32'(exp));
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
    endtask

    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic [7:0] sum,
                          input logic err, input logic [15:0] exp_cnt);
        int lat = 1;
        int base_en;
        base_en = en_cnt;
        push(a, b);
        while (!res_valid && lat < 60) begin
            @(negedge clk);
            lat++;
        end
        check("latency", 32'(lat), 32'(LAT + 3));
        check("res_sum", 32'(res_sum), 32'(sum));
        check("chk_err", 32'(chk_err), 32'(err));
        check("op_cnt", 32'(op_cnt), 32'(exp_cnt));
        check("add_a_held", 32'(add_a), 32'(a));
        check("add_b_held", 32'(add_b), 32'(b));
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        check("add_en_pulses", 32'(en_cnt - base_en), 32'd2);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int ops;
        int base_en;
        int n;
        vecs[0] = '{8'h05, 8'h03, 8'h08, 1'b0};
        vecs[1] = '{8'hFF, 8'h02, 8'h01, 1'b0};
        vecs[2] = '{8'h80, 8'h80, 8'h00, 1'b0};
        vecs[3] = '{8'h7F, 8'h01, 8'h80, 1'b0};
        vecs[4] = '{8'h10, 8'h20, 8'h00, 1'b1};
        vecs[5] = '{8'h33, 8'h44, 8'h77, 1'b1};

        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check_reset_outputs();

        ops = 0;
        for (int i = 0; i < 6; i++) begin
            ops++;
            run_op(vecs[i].a, vecs[i].b, vecs[i].sum, vecs[i].err, 16'(ops));
        end

        // Counter wrap from 0xFFFF; chk_err remains sticky from the injected fault.
        force dut.r_op_cnt = 16'hFFFF;
        @(negedge clk);
        release dut.r_op_cnt;
        @(negedge clk);
        check("wrap_preload", 32'(op_cnt), 32'hFFFF);
        run_op(8'h05, 8'h03, 8'h08, 1'b1, 16'h0000);

        // Backpressure: results not consumed, 4 pairs offered.
        push(8'h01, 8'h01);
        push(8'h02, 8'h02);
        push(8'h03, 8'h03);
        push(8'h04, 8'h04);
        repeat (20) @(negedge clk);
        base_en = en_cnt;
        repeat (20) @(negedge clk);
        check("bp_in_ready", 32'(in_ready), 32'd0);
        check("bp_res_valid", 32'(res_valid), 32'd1);
        check("bp_op_cnt", 32'(op_cnt), 32'd2);
        check("bp_fsm_idle", 32'(en_cnt - base_en), 32'd0);
        pop_expect("bp_res0", 8'h02);
        pop_expect("bp_res1", 8'h04);
        pop_expect("bp_res2", 8'h06);
        pop_expect("bp_res3", 8'h08);
        check("bp_op_cnt_end", 32'(op_cnt), 32'd4);

        // Reset four cycles after LOAD, while the adder is mid-flight.
        push(8'h05, 8'h03);
        n = 0;
        while (!add_en && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("wait_load", 32'(add_en), 32'd1);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_reset_outputs();
        base_en = en_cnt;
        repeat (20) @(negedge clk);
        check("post_rst_no_result", 32'(res_valid), 32'd0);
        check("post_rst_op_cnt", 32'(op_cnt), 32'd0);
        check("post_rst_no_start", 32'(en_cnt - base_en), 32'd0);

        run_op(8'h21, 8'h12, 8'h33, 1'b0, 16'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
